// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and fetch state encoding for the fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_reg
// Description : One-entry valid/ready holding register between fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pc_plus4,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4
);

    // Flush only drops valid; payload is left untouched since it is ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_inst     <= 32'h0;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_inst     <= in_inst;
            out_pc       <= in_pc;
            out_pc_plus4 <= in_pc_plus4;
        end else if (flush) begin
            out_valid    <= 1'b0;
        end
    end

endmodule : fetch_out_reg
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : PC owner and instruction fetch with redirect and fault handling.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                IMEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] c_imem_limit = ADDR_W'(IMEM_WORDS);
    localparam logic [ADDR_W-1:0] c_inst_bytes = ADDR_W'(INST_BYTES);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] r_fault_pc;
    logic [31:0]       r_fetch_count;
    logic              w_pc_ok;
    logic              w_slot_free;
    logic              w_load;
    logic              w_flush;
    logic              w_fault_set;

    assign w_pc_plus4  = r_pc + c_inst_bytes;
    assign w_pc_ok     = (r_pc[1:0] == 2'b00) && ({2'b00, r_pc[ADDR_W-1:2]} < c_imem_limit);
    assign w_slot_free = ~out_valid | out_ready;

    // Redirect beats both load and fault, so a bad target only faults one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_fault_set  = 1'b0;
        case (r_state)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    w_pc_next = redirect_pc;
                    w_flush   = 1'b1;
                end else if (w_slot_free) begin
                    if (w_pc_ok) begin
                        w_load    = 1'b1;
                        w_pc_next = w_pc_plus4;
                    end else begin
                        w_flush      = 1'b1;
                        w_fault_set  = 1'b1;
                        w_state_next = FETCH_FAULT;
                    end
                end
            end
            FETCH_FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_next = FETCH_RUN;
                w_flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_pc    <= '0;
            r_fetch_count <= 32'h0;
        end else begin
            if (w_fault_set) begin
                r_fault_pc <= r_pc;
            end
            if (out_valid && out_ready) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    fetch_out_reg u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (w_load),
        .flush        (w_flush),
        .in_inst      (imem_inst),
        .in_pc        (r_pc),
        .in_pc_plus4  (w_pc_plus4),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4)
    );

    assign imem_addr   = r_pc;
    assign fault       = (r_state == FETCH_FAULT);
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_fetch_count;

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Scoreboard bench for inst_fetch_unit with a program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int          IMEM_WORDS = 128;
    localparam int          IDX_W      = $clog2(IMEM_WORDS);
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    logic [31:0] mem [IMEM_WORDS];

    function automatic bit addr_ok(input logic [31:0] a);
        return ((a % 4) == 0) && ((a / 4) < IMEM_WORDS);
    endfunction

    assign imem_inst = addr_ok(imem_addr) ? mem[imem_addr[IDX_W+1:2]] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted stream is consecutive words from the latest redirect target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_pc       = RESET_PC;
    bit          model_fault  = 1'b0;
    logic [31:0] exp_fault_pc = 32'h0;
    int          hs_count     = 0;
    logic [31:0] last_acc_pc  = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            gen_pc      = RESET_PC;
            model_fault = 1'b0;
            hs_count    = 0;
        end else if (!model_fault) begin
            if (redirect_valid) begin
                exp_q.delete();
                gen_pc = redirect_pc;
            end else if (exp_q.size() == 0 && !addr_ok(gen_pc)) begin
                model_fault  = 1'b1;
                exp_fault_pc = gen_pc;
            end
        end
        while (!model_fault && exp_q.size() < 3 && addr_ok(gen_pc)) begin
            exp_q.push_back('{pc: gen_pc, inst: mem[gen_pc / 4]});
            gen_pc = gen_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("fetch_count", fetch_count, 32'(hs_count));
            chk("fault", {31'b0, fault}, {31'b0, model_fault});
            if (model_fault) begin
                chk("fault_pc", fault_pc, exp_fault_pc);
                chk("valid_in_fault", {31'b0, out_valid}, 32'h0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handshake: actual pc %h required no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_inst", out_inst, e.inst);
                    chk("sb_pc_plus4", out_pc_plus4, e.pc + 32'd4);
                    last_acc_pc = e.pc;
                end
                hs_count++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int fault_cycles;
        int r;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0022_1820;
        mem[1] = 32'hAC01_0000;
        mem[2] = 32'h8C24_0000;

        // Reset state
        #1;
        step();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pc_plus4", out_pc_plus4, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        step();
        rst = 1'b0;

        // Straight-line fetch
        step();
        chk("sl_valid0", {31'b0, out_valid}, 32'h1);
        chk("sl_inst0", out_inst, 32'h0022_1820);
        chk("sl_pc0", out_pc, 32'h0);
        chk("sl_p4_0", out_pc_plus4, 32'h4);
        step();
        chk("sl_inst1", out_inst, 32'hAC01_0000);
        chk("sl_pc1", out_pc, 32'h4);
        chk("sl_p4_1", out_pc_plus4, 32'h8);

        // Stall
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_inst", out_inst, 32'hAC01_0000);
            chk("stall_pc", out_pc, 32'h4);
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_count", fetch_count, 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("sl_inst2", out_inst, 32'h8C24_0000);
        chk("sl_pc2", out_pc, 32'h8);
        chk("sl_p4_2", out_pc_plus4, 32'hC);
        chk("sl_count2", fetch_count, 32'd2);

        // Redirect while holding an unaccepted instruction
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        step();
        chk("rd_flush_valid", {31'b0, out_valid}, 32'h0);
        chk("rd_addr", imem_addr, 32'h14);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        chk("rd_valid", {31'b0, out_valid}, 32'h1);
        chk("rd_pc", out_pc, 32'h14);
        chk("rd_inst", out_inst, mem[5]);
        chk("rd_count", fetch_count, 32'd2);

        // Misaligned redirect target, then sticky fault
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        step();
        chk("mis_valid", {31'b0, out_valid}, 32'h0);
        chk("mis_no_fault_yet", {31'b0, fault}, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_sticky", {31'b0, fault}, 32'h1);
        chk("mis_pc_frozen", imem_addr, 32'h6);
        chk("mis_count_frozen", fetch_count, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mis_rst_fault", {31'b0, fault}, 32'h0);
        chk("mis_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic with redirects, faults and resets
        fault_cycles = 0;
        for (int c = 0; c < 2000; c++) begin
            r              = int'($urandom_range(0, 199));
            out_ready      = ($urandom_range(0, 99) < 70);
            redirect_valid = (r < 12);
            redirect_pc    = (r < 2) ? $urandom : (32'($urandom_range(0, IMEM_WORDS - 1)) << 2);
            rst            = (r == 199) || (fault_cycles >= 3);
            step();
            fault_cycles   = model_fault ? fault_cycles + 1 : 0;
        end
        redirect_valid = 1'b0;

        // Run sequentially off the end of memory
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        n   = 0;
        while (!fault && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL oor_timeout: actual no fault after %0d cycles required fault", n);
        end
        chk("oor_fault_pc", fault_pc, 32'h200);
        chk("oor_last_pc", last_acc_pc, 32'h1FC);

        // Reset asserted mid-stall
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        step();
        chk("mr_held", {31'b0, out_valid}, 32'h1);
        rst = 1'b1;
        step();
        chk("mr_valid", {31'b0, out_valid}, 32'h0);
        chk("mr_addr", imem_addr, RESET_PC);
        chk("mr_count", fetch_count, 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire
